// File: rtl/led_pattern_monitor_if.sv
// Signal bundle between an LED flasher (master) and the pattern monitor (slave).
// The flasher drives the LED bus; the monitor reports the decoded phase and status.
interface led_pattern_monitor_if #(
    parameter int MAX = 15
);
    logic [MAX:0] led;
    logic [2:0]   phase;
    logic [4:0]   count;
    logic         dir;
    logic         seq_done;
    logic         kick;
    logic         err;
    logic [2:0]   err_code;

    modport master (
        output led,
        input  phase, count, dir, seq_done, kick, err, err_code
    );

    modport slave (
        input  led,
        output phase, count, dir, seq_done, kick, err, err_code
    );
endinterface

// File: rtl/led_pattern_monitor.sv
// Watches a thermometer-coded LED flasher and tracks its up/down phase sequence,
// flagging the first illegal sample with a sticky error code.
module led_pattern_monitor #(
    parameter int MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    led_pattern_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP16 = 3'd1,
        DN5  = 3'd2,
        UP11 = 3'd3,
        DN0  = 3'd4,
        UP6  = 3'd5,
        DN0F = 3'd6,
        LOST = 3'd7
    } phase_e;

    localparam logic [4:0] TOP     = 5'(MAX + 1);
    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_THERM = 3'd1;
    localparam logic [2:0] E_STEP  = 3'd2;
    localparam logic [2:0] E_REV   = 3'd3;
    localparam logic [2:0] E_OVER  = 3'd4;
    localparam logic [2:0] E_HOLD  = 3'd5;

    logic [MAX:0] led_q, led_d;
    phase_e       phase_q, phase_d;
    logic [4:0]   count_q, count_d;
    logic         dir_q, dir_d;
    logic         seq_done_q, seq_done_d;
    logic         kick_q, kick_d;
    logic         err_q, err_d;
    logic [2:0]   err_code_q, err_code_d;
    logic [1:0]   hold_q, hold_d;
    logic         from_dn5_q, from_dn5_d;

    logic         therm_ok;
    logic [4:0]   n_new;
    logic         step_up;
    logic         step_dn;
    logic         step_hold;
    logic [2:0]   fault;

    always_comb begin
        therm_ok = 1'b1;
        for (int i = 1; i <= MAX; i++) begin
            if (led_q[i] && !led_q[i-1]) begin
                therm_ok = 1'b0;
            end
        end
        n_new     = 5'($countones(led_q));
        step_up   = (n_new == count_q + 5'd1);
        step_dn   = (count_q != 5'd0) && (n_new == count_q - 5'd1);
        step_hold = (n_new == count_q);
    end

    always_comb begin
        led_d      = bus.led;
        phase_d    = phase_q;
        count_d    = count_q;
        dir_d      = dir_q;
        seq_done_d = 1'b0;
        kick_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        hold_d     = hold_q;
        from_dn5_d = from_dn5_q;
        fault      = E_NONE;

        if (phase_q == LOST) begin
            // Track any clean thermometer value so resync can happen from wherever the flasher is.
            if (therm_ok) begin
                if (n_new != count_q) begin
                    dir_d = (n_new > count_q);
                end
                count_d = n_new;
                hold_d  = 2'd0;
                if (n_new == 5'd0) begin
                    phase_d = IDLE;
                end
            end
        end else begin
            if (!therm_ok) begin
                fault = E_THERM;
            end else if (!(step_up || step_dn || step_hold)) begin
                fault = E_STEP;
            end else begin
                unique case (phase_q)
                    IDLE: begin
                        if (step_up) phase_d = UP16;
                    end
                    UP16: begin
                        if (step_dn) begin
                            if (count_q == TOP) phase_d = DN5;
                            else                fault   = E_REV;
                        end
                    end
                    DN5: begin
                        if (step_dn && count_q == 5'd5) begin
                            fault = E_OVER;
                        end else if (step_up) begin
                            if (count_q == 5'd5) begin
                                phase_d    = UP11;
                                from_dn5_d = 1'b1;
                            end else begin
                                fault = E_REV;
                            end
                        end
                    end
                    UP11: begin
                        // Climbing past 11 is only a legal flick when the climb started at the DN5 turn.
                        if (step_up && count_q == 5'd11) begin
                            if (from_dn5_q) begin
                                phase_d = UP16;
                                kick_d  = 1'b1;
                            end else begin
                                fault = E_OVER;
                            end
                        end else if (step_dn) begin
                            if (count_q == 5'd11) phase_d = DN0;
                            else                  fault   = E_REV;
                        end
                    end
                    DN0: begin
                        if (step_up) begin
                            if (count_q == 5'd0 && hold_q != 2'd0) begin
                                phase_d = UP6;
                            end else if (count_q == 5'd0 || count_q == 5'd5) begin
                                phase_d    = UP11;
                                from_dn5_d = 1'b0;
                                kick_d     = 1'b1;
                            end else begin
                                fault = E_REV;
                            end
                        end
                    end
                    UP6: begin
                        if (step_up && count_q == 5'd6) begin
                            fault = E_OVER;
                        end else if (step_dn) begin
                            if (count_q == 5'd6) phase_d = DN0F;
                            else                 fault   = E_REV;
                        end
                    end
                    DN0F: begin
                        if (step_up) begin
                            fault = E_REV;
                        end else if (step_dn && n_new == 5'd0) begin
                            phase_d    = IDLE;
                            seq_done_d = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
                if (step_hold && phase_q != IDLE && hold_q == 2'd2) begin
                    fault = E_HOLD;
                end
            end

            if (fault != E_NONE) begin
                phase_d    = LOST;
                err_d      = 1'b1;
                kick_d     = 1'b0;
                seq_done_d = 1'b0;
                hold_d     = 2'd0;
                from_dn5_d = from_dn5_q;
                if (!err_q) begin
                    err_code_d = fault;
                end
            end else begin
                count_d = n_new;
                if (step_hold) begin
                    hold_d = (phase_q == IDLE) ? 2'd0 : hold_q + 2'd1;
                end else begin
                    hold_d = 2'd0;
                    dir_d  = step_up;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            phase_q    <= IDLE;
            count_q    <= '0;
            dir_q      <= 1'b0;
            seq_done_q <= 1'b0;
            kick_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            hold_q     <= '0;
            from_dn5_q <= 1'b0;
        end else begin
            led_q      <= led_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            seq_done_q <= seq_done_d;
            kick_q     <= kick_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            hold_q     <= hold_d;
            from_dn5_q <= from_dn5_d;
        end
    end

    assign bus.phase    = phase_q;
    assign bus.count    = count_q;
    assign bus.dir      = dir_q;
    assign bus.seq_done = seq_done_q;
    assign bus.kick     = kick_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
endmodule
